// File: rtl/corefifo_wr_ptr_gray_gen.sv
`default_nettype none
// ============================================================================
// Module      : corefifo_wr_ptr_gray_gen
// Description : Write-side pointer generator for the dual-clock COREFIFO.
//               Holds the binary write counter, drives the RAM write strobe
//               and address, and publishes a registered Gray write pointer
//               for the read-domain synchronizer. It also decodes the
//               synchronized Gray read pointer to derive the write-side
//               fill count, full, almost-full and overflow flags.
//
// Ports       : clk            - write-domain clock, rising edge
//               arstn          - asynchronous active-low reset
//               srstn          - synchronous active-low clear
//               we             - user write request
//               rptr_gray_sync - Gray read pointer, already in clk domain
//               wen_ram        - RAM write strobe (combinational)
//               waddr          - RAM write address
//               wptr_gray      - registered Gray write pointer
//               wrcnt          - registered fill count (write-side view)
//               full / afull   - registered full / almost-full flags
//               overflow       - registered pulse on a rejected write
//
// Options     : COREFIFO_OVERFLOW_FLAG_EN - when defined, the overflow
//               register is built; otherwise overflow is tied to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module corefifo_wr_ptr_gray_gen #(
    parameter int ADDRWIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 srstn,
    input  logic                 we,
    input  logic [ADDRWIDTH:0]   rptr_gray_sync,
    output logic                 wen_ram,
    output logic [ADDRWIDTH-1:0] waddr,
    output logic [ADDRWIDTH:0]   wptr_gray,
    output logic [ADDRWIDTH:0]   wrcnt,
    output logic                 full,
    output logic                 afull,
    output logic                 overflow
);

    localparam int               c_PW     = ADDRWIDTH + 1;
    localparam logic [c_PW-1:0]  c_ONE    = c_PW'(1);
    localparam logic [c_PW-1:0]  c_DEPTH  = c_PW'(1) << ADDRWIDTH;
    localparam logic [c_PW-1:0]  c_AFULL  = c_PW'(AFULL_THRESH);

    logic [c_PW-1:0] wbin_q;
    logic [c_PW-1:0] wbin_d;
    logic [c_PW-1:0] gray_q;
    logic [c_PW-1:0] gray_d;
    logic [c_PW-1:0] cnt_q;
    logic [c_PW-1:0] cnt_d;
    logic [c_PW-1:0] rbin;
    logic            full_q;
    logic            afull_q;
    logic            acc;

    always_comb begin
        acc    = we & ~full_q;
        wbin_d = wbin_q;
        if (acc) begin
            wbin_d = wbin_q + c_ONE;
        end
        gray_d = wbin_d ^ (wbin_d >> 1);

        // Gray-to-binary: each binary bit is the XOR of all Gray bits at
        // or above its position.
        rbin = '0;
        for (int i = 0; i < c_PW; i++) begin
            rbin[i] = ^(rptr_gray_sync >> i);
        end

        // Write advance and read advance in the same cycle both land here,
        // so they cancel in the count and full cannot glitch.
        cnt_d = wbin_d - rbin;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wbin_q  <= '0;
            gray_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else if (!srstn) begin
            wbin_q  <= '0;
            gray_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            gray_q  <= gray_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == c_DEPTH);
            afull_q <= (cnt_d >= c_AFULL);
        end
    end

`ifdef COREFIFO_OVERFLOW_FLAG_EN
    logic overflow_q;

    // Held high for every cycle that a write is attempted against a full FIFO.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            overflow_q <= 1'b0;
        end else if (!srstn) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= we & full_q;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    // The strobe is masked while either reset is active so a write that
    // coincides with a reset never reaches the RAM; the pointer discards it
    // through the reset branch anyway.
    assign wen_ram   = acc & arstn & srstn;
    assign waddr     = wbin_q[ADDRWIDTH-1:0];
    assign wptr_gray = gray_q;
    assign wrcnt     = cnt_q;
    assign full      = full_q;
    assign afull     = afull_q;

endmodule
`default_nettype wire

// File: tb/tb_corefifo_wr_ptr_gray_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_corefifo_wr_ptr_gray_gen
// Description : Directed self-checking bench for corefifo_wr_ptr_gray_gen
//               with ADDRWIDTH=3, AFULL_THRESH=6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_corefifo_wr_ptr_gray_gen;

    localparam int c_AW = 3;
`ifdef COREFIFO_OVERFLOW_FLAG_EN
    localparam logic c_OVF = 1'b1;
`else
    localparam logic c_OVF = 1'b0;
`endif

    logic            clk;
    logic            arstn;
    logic            srstn;
    logic            we;
    logic [c_AW:0]   rptr_gray_sync;
    logic            wen_ram;
    logic [c_AW-1:0] waddr;
    logic [c_AW:0]   wptr_gray;
    logic [c_AW:0]   wrcnt;
    logic            full;
    logic            afull;
    logic            overflow;

    int n_checks = 0;
    int n_fail   = 0;

    corefifo_wr_ptr_gray_gen #(
        .ADDRWIDTH    (c_AW),
        .AFULL_THRESH (6)
    ) dut (
        .clk            (clk),
        .arstn          (arstn),
        .srstn          (srstn),
        .we             (we),
        .rptr_gray_sync (rptr_gray_sync),
        .wen_ram        (wen_ram),
        .waddr          (waddr),
        .wptr_gray      (wptr_gray),
        .wrcnt          (wrcnt),
        .full           (full),
        .afull          (afull),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arstn = 1'b0; srstn = 1'b1; we = 1'b1; rptr_gray_sync = '0;
        #3;
        n_checks++;
        if ({wptr_gray, wrcnt, waddr, full, afull, overflow, wen_ram} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: gray=%h cnt=%h addr=%h full=%b afull=%b ovf=%b wen=%b required all 0",
                     wptr_gray, wrcnt, waddr, full, afull, overflow, wen_ram);
        end
        tick();
        n_checks++;
        if ({wptr_gray, wrcnt, wen_ram} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: gray=%h cnt=%h wen=%b required 0", wptr_gray, wrcnt, wen_ram);
        end
        we = 1'b0;
        arstn = 1'b1;
        tick();
        we = 1'b1;
        tick();
        tick();
        n_checks++;
        if (wptr_gray !== 4'h3 || wrcnt !== 4'd2) begin
            n_fail++;
            $display("FAIL pre_srst: gray=%h cnt=%0d required 3 / 2", wptr_gray, wrcnt);
        end
        srstn = 1'b0;
        tick();
        n_checks++;
        if (wptr_gray !== 4'h0 || wrcnt !== 4'd0 || waddr !== 3'd0) begin
            n_fail++;
            $display("FAIL sync_reset: gray=%h cnt=%0d addr=%0d required 0 / 0 / 0", wptr_gray, wrcnt, waddr);
        end
        srstn = 1'b1;
        we = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        logic [3:0] exp_gray [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        logic [3:0] prev;
        prev = wptr_gray;
        rptr_gray_sync = '0;
        we = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (waddr !== 3'(k) || wen_ram !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_addr[%0d]: addr=%0d wen=%b required %0d / 1", k, waddr, wen_ram, k);
            end
            tick();
            n_checks++;
            if (wptr_gray !== exp_gray[k] || wrcnt !== 4'(k + 1)) begin
                n_fail++;
                $display("FAIL fill_gray[%0d]: gray=%h cnt=%0d required %h / %0d",
                         k, wptr_gray, wrcnt, exp_gray[k], k + 1);
            end
            n_checks++;
            if ($countones(wptr_gray ^ prev) != 1) begin
                n_fail++;
                $display("FAIL fill_hamming[%0d]: %h -> %h required 1 bit change", k, prev, wptr_gray);
            end
            prev = wptr_gray;
            n_checks++;
            if (afull !== (k >= 5) || full !== (k == 7)) begin
                n_fail++;
                $display("FAIL fill_flags[%0d]: afull=%b full=%b required %b / %b",
                         k, afull, full, (k >= 5), (k == 7));
            end
        end
    endtask

    task automatic test_overflow();
        we = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (wen_ram !== 1'b0 || waddr !== 3'd0) begin
                n_fail++;
                $display("FAIL ovf_wen[%0d]: wen=%b addr=%0d required 0 / 0", k, wen_ram, waddr);
            end
            tick();
            n_checks++;
            if (wptr_gray !== 4'hC || overflow !== c_OVF || full !== 1'b1 || wrcnt !== 4'd8) begin
                n_fail++;
                $display("FAIL ovf_hold[%0d]: gray=%h ovf=%b full=%b cnt=%0d required C / %b / 1 / 8",
                         k, wptr_gray, overflow, full, wrcnt, c_OVF);
            end
        end
        we = 1'b0;
        tick();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b required 0", overflow);
        end
    endtask

    task automatic test_release();
        rptr_gray_sync = 4'h1;
        tick();
        n_checks++;
        if (full !== 1'b0 || wrcnt !== 4'd7 || afull !== 1'b1) begin
            n_fail++;
            $display("FAIL release_1: full=%b cnt=%0d afull=%b required 0 / 7 / 1", full, wrcnt, afull);
        end
        rptr_gray_sync = 4'h3;
        tick();
        n_checks++;
        if (wrcnt !== 4'd6 || afull !== 1'b1) begin
            n_fail++;
            $display("FAIL release_3: cnt=%0d afull=%b required 6 / 1", wrcnt, afull);
        end
        rptr_gray_sync = 4'h2;
        tick();
        n_checks++;
        if (wrcnt !== 4'd5 || afull !== 1'b0) begin
            n_fail++;
            $display("FAIL release_2: cnt=%0d afull=%b required 5 / 0", wrcnt, afull);
        end
    endtask

    task automatic test_simultaneous();
        we = 1'b1;
        rptr_gray_sync = 4'h6;
        tick();
        we = 1'b0;
        n_checks++;
        if (wrcnt !== 4'd5 || full !== 1'b0 || wptr_gray !== 4'hD) begin
            n_fail++;
            $display("FAIL simultaneous: cnt=%0d full=%b gray=%h required 5 / 0 / D", wrcnt, full, wptr_gray);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] b;
        srstn = 1'b0;
        rptr_gray_sync = '0;
        tick();
        srstn = 1'b1;
        we = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            b = 4'(k - 1);
            rptr_gray_sync = b ^ (b >> 1);
            tick();
            n_checks++;
            if (full !== 1'b0 || wrcnt !== 4'd1) begin
                n_fail++;
                $display("FAIL wrap[%0d]: full=%b cnt=%0d required 0 / 1", k, full, wrcnt);
            end
        end
        we = 1'b0;
        n_checks++;
        if (wptr_gray !== 4'h0) begin
            n_fail++;
            $display("FAIL wrap_gray: gray=%h required 0", wptr_gray);
        end
    endtask

    task automatic test_async_reset();
        we = 1'b1;
        rptr_gray_sync = '0;
        tick();
        tick();
        #2;
        arstn = 1'b0;
        #1;
        n_checks++;
        if (wptr_gray !== 4'h0 || wrcnt !== 4'd0 || wen_ram !== 1'b0) begin
            n_fail++;
            $display("FAIL async_mid: gray=%h cnt=%0d wen=%b required 0 / 0 / 0", wptr_gray, wrcnt, wen_ram);
        end
        we = 1'b0;
        tick();
        arstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/corefifo_wr_ptr_gray_gen.md
# corefifo_wr_ptr_gray_gen

Write-side pointer generator for the dual-clock COREFIFO. It sits in the write-clock domain and holds the binary write counter. It drives the RAM write enable and address. It produces the registered Gray-coded write pointer that the read domain's N-stage synchronizer samples. It also takes the synchronized Gray read pointer back from that synchronizer and derives the write-side fill count, full, almost-full and overflow.

## Interface
Parameters:
- ADDRWIDTH, 3, RAM address width; FIFO depth = 2^ADDRWIDTH; pointers are ADDRWIDTH+1 bits.
- AFULL_THRESH, 6, afull asserts when fill count >= this value; legal range 1..2^ADDRWIDTH.

Ports:
- clk  in  1  write-domain clock, rising edge.
- arstn  in  1  asynchronous active-low reset; clears all state immediately.
- srstn  in  1  synchronous active-low clear; sampled on clk, same effect as arstn.
- we  in  1  write request from user.
- rptr_gray_sync  in  ADDRWIDTH+1  read pointer, Gray code, already synchronized into clk domain.
- wen_ram  out  1  RAM write strobe = we & ~full (combinational).
- waddr  out  ADDRWIDTH  RAM write address = wbin[ADDRWIDTH-1:0].
- wptr_gray  out  ADDRWIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- wrcnt  out  ADDRWIDTH+1  registered fill count as seen from the write side.
- full  out  1  registered full flag.
- afull  out  1  registered almost-full flag.
- overflow  out  1  registered one-cycle pulse on a rejected write (see Configuration).

## Operation
- Reset (arstn low asynchronously, or srstn low at a clk edge):
  - wbin=0, wptr_gray=0, wrcnt=0, full=0, afull=0, overflow=0.
  - waddr therefore reads 0.
- Accept: acc = we & ~full.
  - On acc, wbin_nxt = wbin+1 modulo 2^(ADDRWIDTH+1); otherwise wbin_nxt = wbin.
- wptr_gray <= wbin_nxt ^ (wbin_nxt >> 1). It is driven directly from a flop with no logic after the register, and changes at most 1 bit per clock.
- Read pointer decode:
  - rbin = gray-to-binary(rptr_gray_sync), where rbin[i] = XOR of rptr_gray_sync[ADDRWIDTH:i].
  - rbin is combinational from the input. It is not re-registered in this block.
- Count: cnt_nxt = (wbin_nxt - rbin) modulo 2^(ADDRWIDTH+1). Legal range is 0..2^ADDRWIDTH.
- Flag and count registers:
  - wrcnt <= cnt_nxt.
  - full <= (cnt_nxt == 2^ADDRWIDTH).
  - afull <= (cnt_nxt >= AFULL_THRESH).
- Write while full:
  - wen_ram=0; wbin, waddr and wptr_gray hold.
  - overflow <= 1 for one cycle. It stays high on consecutive cycles for as long as we & full persists.
- Wrap-around: the extra MSB distinguishes full from empty. With equal low bits, differing MSB means full and equal MSB means empty.
- Simultaneous write and read-pointer advance in one cycle: both are folded into cnt_nxt, so the count is unchanged and full does not toggle.

## Timing
- wen_ram and waddr are valid in the same cycle as we. The RAM captures data at the same clk edge that advances wbin.
- wptr_gray, wrcnt, full and afull reflect a write 1 clk after the accepting edge.
- The write that fills the FIFO raises full on that same edge. A write in the very next cycle is therefore already rejected.
- A change on rptr_gray_sync is reflected in wrcnt/full/afull 1 clk later.
  - The end-to-end read-to-full-release latency is this plus the synchronizer depth. That latency is pessimistic by design.
- Reset mid-operation: outputs go to reset values within the same cycle as arstn falls, or at the next edge for srstn. Any in-flight write is discarded.

## Configuration
- Macro COREFIFO_OVERFLOW_FLAG_EN.
  - Defined: overflow register implemented as specified above.
  - Undefined: no overflow register; overflow tied to 0. All other behaviour is identical.

## Test plan
Parameters for all cases: ADDRWIDTH=3, AFULL_THRESH=6.
- Reset: hold arstn low with we=1 -> all outputs 0 and wen_ram=0. Release, then pulse srstn low for 1 cycle mid-stream -> wptr_gray=0 and wrcnt=0 at that edge.
- Fill with rptr_gray_sync=0, 8 back-to-back writes:
  - wptr_gray sequence = 1,3,2,6,7,5,4,C (hex).
  - waddr = 0..7.
  - afull rises after the 6th write.
  - full rises after the 8th write with wrcnt=8.
  - Each wptr_gray step has Hamming distance 1.
- Overflow: while full, we=1 for 3 cycles -> wen_ram=0, waddr=0, wptr_gray stays C, overflow=1 for 3 cycles. With the macro undefined, overflow stays 0.
- Release:
  - Set rptr_gray_sync=1 -> next clk full=0, wrcnt=7.
  - Set it to 3 -> wrcnt=6, afull stays 1.
  - Set it to 2 -> wrcnt=5, afull=0.
- Simultaneous: at wrcnt=5, write and rptr_gray_sync 2->6 in the same cycle -> wrcnt stays 5, full=0.
- Wrap: 16 writes with rptr_gray_sync tracking 1 behind -> wptr_gray returns to 0 after write 16, and full never asserts.
